// File: rtl/serial_rca.sv
// Chunk-serial ripple-carry adder/subtractor: adds CHUNK bits per clock, LSB slice first,
// and publishes the full result, carry-out and overflow in a single one-cycle DONE state.
module serial_rca #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned CntW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [CHUNK-1:0]  a_sl, b_sl, sum_sl;
  logic              c_out, c_msb, last;
  logic [WIDTH-1:0]  acc_next;

  // Operands shift right so the active slice is always the low CHUNK bits.
  assign a_sl = a_q[CHUNK-1:0];
  assign b_sl = b_q[CHUNK-1:0];
  assign {c_out, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);
  // Carry into the slice MSB recovered from its sum bit; on the last slice this is bit WIDTH-1.
  assign c_msb    = sum_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
  assign last     = (cnt_q == CntW'(NCH - 1));
  assign acc_next = (acc_q >> CHUNK) | (WIDTH'(sum_sl) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StBusy;
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = c_out;
        acc_d   = acc_next;
        cnt_d   = cnt_q + CntW'(1);
        if (last) begin
          state_d = StDone;
          s_d     = acc_next;
          co_d    = c_out;
          ovf_d   = c_msb ^ c_out;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign done = (state_q == StDone);
  assign S    = s_q;
  assign Co   = co_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_rca.sv
// Bench for serial_rca: table vectors and scoreboard on a 16/4 instance, a 16/16 instance,
// and a random sweep over four 8-bit instances with CHUNK = 1, 2, 4, 8.
module tb_serial_rca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;

  logic        start, cin, sub, busy, done, co, ovf;
  logic [15:0] a, b, s;

  logic        w_start, w_cin, w_sub, w_busy, w_done, w_co, w_ovf;
  logic [15:0] w_a, w_b, w_s;

  logic        start8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8 [4];
  logic        done8 [4];
  logic [7:0]  s8    [4];
  logic        co8   [4];
  logic        ovf8  [4];

  serial_rca #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin), .sub(sub),
    .busy(busy), .done(done), .S(s), .Co(co), .Ovf(ovf)
  );

  serial_rca #(.WIDTH(16), .CHUNK(16)) u_wide (
    .clk(clk), .rst_n(rst_n), .start(w_start), .A(w_a), .B(w_b), .Cin(w_cin), .sub(w_sub),
    .busy(w_busy), .done(w_done), .S(w_s), .Co(w_co), .Ovf(w_ovf)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    serial_rca #(.WIDTH(8), .CHUNK(1 << g)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8), .sub(sub8),
      .busy(busy8[g]), .done(done8[g]), .S(s8[g]), .Co(co8[g]), .Ovf(ovf8[g])
    );
  end

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ovf;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co, ovf;
    int          due;
  } exp_t;

  typedef struct {
    logic [7:0] s;
    logic       co, ovf;
  } exp8_t;

  exp_t  sbq[$];
  exp8_t q8[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic exp_t model16(input logic [15:0] ia, ib, input logic ic, is);
    logic [15:0] bb;
    logic        c;
    logic [16:0] full;
    logic [15:0] low;
    exp_t        e;
    bb    = is ? ~ib : ib;
    c     = is ? 1'b1 : ic;
    full  = {1'b0, ia} + {1'b0, bb} + 17'(c);
    low   = {1'b0, ia[14:0]} + {1'b0, bb[14:0]} + 16'(c);
    e.s   = full[15:0];
    e.co  = full[16];
    e.ovf = low[15] ^ full[16];
    e.due = 0;
    return e;
  endfunction

  function automatic exp8_t model8(input logic [7:0] ia, ib, input logic ic, is);
    logic [7:0] bb;
    logic [8:0] full;
    exp8_t      e;
    bb    = is ? ~ib : ib;
    full  = {1'b0, ia} + {1'b0, bb} + 9'(is ? 1'b1 : ic);
    e.s   = full[7:0];
    e.co  = full[8];
    e.ovf = (ia[7] == bb[7]) && (full[7] != ia[7]);
    return e;
  endfunction

  // Caller sits on a negedge; start is held for exactly one rising edge.
  task automatic go(input logic [15:0] ia, ib, input logic ic, is, input exp_t e);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    e.due = cyc + 1 + 4;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_done(input string name);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check({name, " done timeout"}, 32'(done), 32'd1);
      sbq.delete();
      return;
    end
    check({name, " expected pending"}, 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    check({name, " S"},   32'(s),   32'(e.s));
    check({name, " Co"},  32'(co),  32'(e.co));
    check({name, " Ovf"}, 32'(ovf), 32'(e.ovf));
    check({name, " latency"}, 32'(cyc), 32'(e.due));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tv [8];
    exp_t  e;
    exp8_t e8;
    int    nb, t1, seen, t0;
    int    seen8 [4];

    tv[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tv[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tv[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    w_start = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

    #1;
    check("reset S",    32'(s),    32'd0);
    check("reset Co",   32'(co),   32'd0);
    check("reset Ovf",  32'(ovf),  32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      e.s = tv[i].s; e.co = tv[i].co; e.ovf = tv[i].ovf; e.due = 0;
      go(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, e);
      if (i == 0) begin
        nb = 0;
        for (int k = 0; k < 10 && !done; k++) begin
          if (busy) nb++;
          @(negedge clk);
        end
        check("busy cycles", 32'(nb), 32'd4);
      end
      expect_done($sformatf("vec%0d", i));
      @(negedge clk);
      if (i == 0) begin
        check("vec0 done pulse width", 32'(done), 32'd0);
        check("vec0 idle busy",        32'(busy), 32'd0);
      end
    end

    // start held through BUSY with changing operands: only the first capture counts
    e = model16(16'h1111, 16'h2222, 1'b1, 1'b0);
    a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0; start = 1'b1;
    e.due = cyc + 1 + 4;
    sbq.push_back(e);
    repeat (3) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); cin = ~cin; sub = ~sub;
    end
    @(negedge clk);
    start = 1'b0;
    expect_done("hold start");
    @(negedge clk);

    // back-to-back: second start issued in the DONE cycle
    go(16'h0F0F, 16'h0101, 1'b0, 1'b0, model16(16'h0F0F, 16'h0101, 1'b0, 1'b0));
    expect_done("b2b first");
    t1 = cyc;
    go(16'hA5A5, 16'h1234, 1'b1, 1'b0, model16(16'hA5A5, 16'h1234, 1'b1, 1'b0));
    expect_done("b2b second");
    check("b2b spacing", 32'(cyc - t1), 32'd5);
    @(negedge clk);

    // reset during the second BUSY cycle
    go(16'h3333, 16'h4444, 1'b0, 1'b0, model16(16'h3333, 16'h4444, 1'b0, 1'b0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort S",    32'(s),    32'd0);
    check("abort Co",   32'(co),   32'd0);
    check("abort Ovf",  32'(ovf),  32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort no done", 32'(seen), 32'd0);
    go(16'hABCD, 16'h1234, 1'b0, 1'b1, model16(16'hABCD, 16'h1234, 1'b0, 1'b1));
    expect_done("post reset");
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      go(ra, rb, rc, rs, model16(ra, rb, rc, rs));
      expect_done($sformatf("rand16 %0d", i));
      @(negedge clk);
    end

    // CHUNK == WIDTH: one BUSY cycle then DONE
    w_a = 16'h1234; w_b = 16'h4321; w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    check("wide busy", 32'(w_busy), 32'd1);
    check("wide done early", 32'(w_done), 32'd0);
    @(negedge clk);
    check("wide done", 32'(w_done), 32'd1);
    check("wide S",    32'(w_s),    32'h5555);
    check("wide Co",   32'(w_co),   32'd0);
    check("wide Ovf",  32'(w_ovf),  32'd0);

    // WIDTH=8 sweep across all four chunk sizes
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
      q8.push_back(model8(a8, b8, cin8, sub8));
      t0 = cyc;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      for (int g = 0; g < 4; g++) seen8[g] = 0;
      e8 = q8[0];
      for (int k = 0; k < 10; k++) begin
        for (int g = 0; g < 4; g++) begin
          if (done8[g]) begin
            seen8[g]++;
            check($sformatf("sw%0d c%0d S", it, 1 << g),   32'(s8[g]),   32'(e8.s));
            check($sformatf("sw%0d c%0d Co", it, 1 << g),  32'(co8[g]),  32'(e8.co));
            check($sformatf("sw%0d c%0d Ovf", it, 1 << g), 32'(ovf8[g]), 32'(e8.ovf));
            check($sformatf("sw%0d c%0d latency", it, 1 << g), 32'(cyc - t0),
                  32'((8 >> g) + 1));
          end
        end
        @(negedge clk);
      end
      for (int g = 0; g < 4; g++) begin
        check($sformatf("sw%0d c%0d done count", it, 1 << g), 32'(seen8[g]), 32'd1);
        check($sformatf("sw%0d c%0d idle", it, 1 << g), 32'(busy8[g]), 32'd0);
      end
      void'(q8.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
